// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard event path: scan-code prefixes,
// the layout of a 10-bit key event, and the frame receiver states.
package ps2_pkg;

   localparam logic [7:0] PREFIX_EXT   = 8'hE0;
   localparam logic [7:0] PREFIX_BREAK = 8'hF0;

   // Event layout: {ext, release, code[7:0]}
   localparam int EVT_W        = 10;
   localparam int EVT_EXT_BIT  = 9;
   localparam int EVT_REL_BIT  = 8;
   localparam int EVT_CODE_LSB = 0;

   typedef logic [EVT_W-1:0] ps2_evt_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } frame_state_t;

   function automatic ps2_evt_t make_evt(input logic ext, input logic rel, input logic [7:0] code);
      ps2_evt_t e;
      e = '0;
      e[EVT_EXT_BIT]          = ext;
      e[EVT_REL_BIT]          = rel;
      e[EVT_CODE_LSB +: 8]    = code;
      return e;
   endfunction

endpackage

// File: rtl/ps2_keyboard_events_if.sv
// Push/pop bundle between the key event producer and the event FIFO.
// The master side pushes events and requests pops; the slave side is the FIFO.
interface ps2_keyboard_events_if
   import ps2_pkg::*;
#(
   parameter int WIDTH = EVT_W,
   parameter int LW    = 4
);
   logic             push_valid;
   logic [WIDTH-1:0] push_data;
   logic             pop_ready;
   logic             pop_valid;
   logic [WIDTH-1:0] pop_data;
   logic [LW-1:0]    level;
   logic             overflow;

   modport master (
      output push_valid, push_data, pop_ready,
      input  pop_valid, pop_data, level, overflow
   );

   modport slave (
      input  push_valid, push_data, pop_ready,
      output pop_valid, pop_data, level, overflow
   );
endinterface

// File: rtl/ps2_event_fifo.sv
// Show-ahead event FIFO: the head entry is always visible on pop_data.
// A push into a full FIFO succeeds only when a pop frees a slot in the same
// cycle; otherwise the event is dropped and the sticky overflow flag is set.
module ps2_event_fifo
   import ps2_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = EVT_W
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   ps2_keyboard_events_if.slave bus
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             r_ovf;
   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;

   assign w_full  = (r_count == (AW+1)'(DEPTH));
   assign w_empty = (r_count == '0);
   assign w_pop   = bus.pop_ready && !w_empty;
   assign w_push  = bus.push_valid && (!w_full || w_pop);

   // Storage write; left unreset so it maps onto plain memory
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= bus.push_data;
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
         else if (w_pop && !w_push) r_count <= r_count - (AW+1)'(1);
         if (bus.push_valid && !w_push) r_ovf <= 1'b1;
      end
   end

   assign bus.pop_valid = !w_empty;
   assign bus.pop_data  = w_empty ? '0 : r_mem[r_rd_ptr];
   assign bus.level     = r_count;
   assign bus.overflow  = r_ovf;

endmodule

// File: rtl/ps2_keyboard_events.sv
// PS/2 keyboard receiver: synchronises and de-glitches the keyboard lines,
// deframes 11-bit frames, folds E0/F0 prefixes into flags and queues
// {ext, release, code} events for a ready/valid consumer.
module ps2_keyboard_events
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH     = 8,
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic                          CLK100MHZ,
   input  logic                          CPU_RESETN,
   input  logic                          PS2_CLK,
   input  logic                          PS2_DATA,
   input  logic                          EVT_READY,
   output logic                          EVT_VALID,
   output logic [EVT_W-1:0]              EVT_DATA,
   output logic [31:0]                   RAW_HISTORY,
   output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
   output logic                          FRAME_ERR,
   output logic [7:0]                    ERR_COUNT,
   output logic                          OVERFLOW
);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
   logic          r_filt_clk;
   logic [FW-1:0] r_filt_cnt;
   logic          r_strobe;
   logic          w_filt_flip;

   frame_state_t  r_state, w_state_next;
   logic [2:0]    r_bit_cnt;
   logic [7:0]    r_shift;
   logic          r_ones;
   logic          r_par_ok;
   logic [TW-1:0] r_tmo_cnt;
   logic          w_tmo;
   logic          w_frame_ok;
   logic          w_frame_err;
   logic          r_byte_vld;
   logic          r_frame_err;
   logic [7:0]    r_err_cnt;

   logic [31:0]   r_hist;
   logic          r_ext, r_rel;
   logic          w_is_ext, w_is_brk;

   ps2_keyboard_events_if #(.WIDTH(EVT_W), .LW(LW)) w_evt_bus ();

   // Two-flop synchronisers; both lines idle high
   always_ff @(posedge CLK100MHZ) begin
      if (!CPU_RESETN) begin
         r_clk_s1 <= 1'b1;
         r_clk_s2 <= 1'b1;
         r_dat_s1 <= 1'b1;
         r_dat_s2 <= 1'b1;
      end else begin
         r_clk_s1 <= PS2_CLK;
         r_clk_s2 <= r_clk_s1;
         r_dat_s1 <= PS2_DATA;
         r_dat_s2 <= r_dat_s1;
      end
   end

   // A new PS2_CLK level is accepted after FILTER_LEN consecutive differing samples
   assign w_filt_flip = (r_clk_s2 != r_filt_clk) && (r_filt_cnt == FW'(FILTER_LEN - 1));

   // Glitch filter and one-cycle strobe on each accepted falling edge
   always_ff @(posedge CLK100MHZ) begin
      if (!CPU_RESETN) begin
         r_filt_clk <= 1'b1;
         r_filt_cnt <= '0;
         r_strobe   <= 1'b0;
      end else begin
         r_strobe <= w_filt_flip && r_filt_clk;
         if (r_clk_s2 == r_filt_clk) begin
            r_filt_cnt <= '0;
         end else if (w_filt_flip) begin
            r_filt_clk <= r_clk_s2;
            r_filt_cnt <= '0;
         end else begin
            r_filt_cnt <= r_filt_cnt + FW'(1);
         end
      end
   end

   assign w_tmo = (r_state != ST_IDLE) && !r_strobe && (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

   // Frame state register
   always_ff @(posedge CLK100MHZ) begin
      if (!CPU_RESETN) r_state <= ST_IDLE;
      else             r_state <= w_state_next;
   end

   // Frame next-state and accept/reject decisions; a timeout overrides everything
   always_comb begin
      w_state_next = r_state;
      w_frame_ok   = 1'b0;
      w_frame_err  = 1'b0;
      case (r_state)
         ST_IDLE:   if (r_strobe && !r_dat_s2) w_state_next = ST_DATA;
         ST_DATA:   if (r_strobe && (r_bit_cnt == 3'd7)) w_state_next = ST_PARITY;
         ST_PARITY: if (r_strobe) w_state_next = ST_STOP;
         ST_STOP: begin
            if (r_strobe) begin
               w_state_next = ST_IDLE;
               if (r_par_ok && r_dat_s2) w_frame_ok  = 1'b1;
               else                      w_frame_err = 1'b1;
            end
         end
         default:   w_state_next = ST_IDLE;
      endcase
      if (w_tmo) begin
         w_state_next = ST_IDLE;
         w_frame_err  = 1'b1;
      end
   end

   // Bit shifting, parity tracking, idle timer and error accounting
   always_ff @(posedge CLK100MHZ) begin
      if (!CPU_RESETN) begin
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_ones      <= 1'b0;
         r_par_ok    <= 1'b0;
         r_tmo_cnt   <= '0;
         r_byte_vld  <= 1'b0;
         r_frame_err <= 1'b0;
         r_err_cnt   <= '0;
      end else begin
         r_byte_vld  <= w_frame_ok;
         r_frame_err <= w_frame_err;
         if (w_frame_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
         if ((r_state == ST_IDLE) || r_strobe) r_tmo_cnt <= '0;
         else                                  r_tmo_cnt <= r_tmo_cnt + TW'(1);
         if (r_strobe) begin
            case (r_state)
               ST_IDLE: begin
                  r_bit_cnt <= '0;
                  r_ones    <= 1'b0;
               end
               ST_DATA: begin
                  r_shift   <= {r_dat_s2, r_shift[7:1]};
                  r_ones    <= r_ones ^ r_dat_s2;
                  r_bit_cnt <= r_bit_cnt + 3'd1;
               end
               ST_PARITY: r_par_ok <= r_ones ^ r_dat_s2;
               default: ;
            endcase
         end
      end
   end

   assign w_is_ext = (r_shift == PREFIX_EXT);
   assign w_is_brk = (r_shift == PREFIX_BREAK);

   // Byte history and prefix flags, updated the cycle after a frame is accepted
   always_ff @(posedge CLK100MHZ) begin
      if (!CPU_RESETN) begin
         r_hist <= '0;
         r_ext  <= 1'b0;
         r_rel  <= 1'b0;
      end else if (r_byte_vld) begin
         r_hist <= {r_hist[23:0], r_shift};
         if (w_is_ext) begin
            r_ext <= 1'b1;
         end else if (w_is_brk) begin
            r_rel <= 1'b1;
         end else begin
            r_ext <= 1'b0;
            r_rel <= 1'b0;
         end
      end
   end

   assign w_evt_bus.push_valid = r_byte_vld && !w_is_ext && !w_is_brk;
   assign w_evt_bus.push_data  = make_evt(r_ext, r_rel, r_shift);
   assign w_evt_bus.pop_ready  = EVT_READY;

   ps2_event_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EVT_W)) u_fifo (
      .i_clk   (CLK100MHZ),
      .i_rst_n (CPU_RESETN),
      .bus     (w_evt_bus)
   );

   assign EVT_VALID   = w_evt_bus.pop_valid;
   assign EVT_DATA    = w_evt_bus.pop_data;
   assign FIFO_LEVEL  = w_evt_bus.level;
   assign OVERFLOW    = w_evt_bus.overflow;
   assign RAW_HISTORY = r_hist;
   assign FRAME_ERR   = r_frame_err;
   assign ERR_COUNT   = r_err_cnt;

endmodule
